// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Shares one single-ported 32-bit SRAM between the instruction-fetch port
// and the data (MEM-stage) port of the core. Grants are combinational and
// returned in the same cycle as the request. Read data comes back one cycle
// after the grant and is steered to whichever port won the read.
//
// Optional starvation guard: define IMEM_DMEM_ARB_STARVE_GUARD_EN to build
// the denied-fetch counter and the FORCE_IF state. Without it, arbitration
// is pure fixed priority (data over fetch) and STARVE_LIMIT is ignored.
//
// Arbitration states (guard build only):
//   state     | meaning
//   ----------+-------------------------------------------------------
//   PRIO_D    | data wins a collision (reset state)
//   FORCE_IF  | fetch wins a collision; left after fetch is granted
//
// Parameters:
//   ADDR_W       word-address width presented to the SRAM
//   STARVE_LIMIT consecutive denied fetch cycles before fetch is forced
//                ahead of data (1..15)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req_i/if_addr_i       fetch read request and address
//   if_gnt_o                 fetch accepted this cycle
//   if_rvalid_o/if_rdata_o   fetch read response
//   d_req_i/d_we_i/d_addr_i  data request, store flag, address
//   d_wdata_i/d_wmask_i      store data and byte-lane mask
//   d_gnt_o                  data accepted this cycle
//   d_rvalid_o/d_rdata_o     load response
//   sram_*_o                 SRAM strobe, write enable, address, data, mask
//   sram_rdata_i             SRAM read data, one cycle after a read strobe
// ---------------------------------------------------------------------------
module imem_dmem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,

  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_wmask_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,

  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic [3:0]        sram_wmask_o,
  input  logic [31:0]       sram_rdata_i
);

  logic        w_if_gnt;
  logic        w_d_gnt;
  logic        w_force_if;
  logic        w_rd_gnt;
  logic        w_if_rvalid;
  logic        w_d_rvalid;

  logic        r_tag_valid;
  logic        r_tag_is_d;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  // -------------------------------------------------------------------------
  // Starvation guard
  // -------------------------------------------------------------------------
`ifdef IMEM_DMEM_ARB_STARVE_GUARD_EN
  typedef enum logic {
    ST_PRIO_D   = 1'b0,
    ST_FORCE_IF = 1'b1
  } arb_state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  arb_state_t r_state;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_cnt_nxt;

  // Counts consecutive denied fetch cycles; saturates rather than wrapping.
  always_comb begin
    w_cnt_nxt = 4'd0;
    if (if_req_i && !w_if_gnt) begin
      w_cnt_nxt = (r_starve_cnt == 4'hF) ? r_starve_cnt : r_starve_cnt + 4'd1;
    end
  end

  // FORCE_IF is entered on the same edge the counter reaches the limit, so a
  // continuously denied fetch wins on cycle STARVE_LIMIT+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_PRIO_D;
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= w_cnt_nxt;
      case (r_state)
        ST_PRIO_D: begin
          if (w_cnt_nxt >= LP_LIMIT) r_state <= ST_FORCE_IF;
        end
        ST_FORCE_IF: begin
          if (w_if_gnt) r_state <= ST_PRIO_D;
        end
        default: r_state <= ST_PRIO_D;
      endcase
    end
  end

  assign w_force_if = (r_state == ST_FORCE_IF);
`else
  logic [3:0] w_unused_limit;
  assign w_unused_limit = 4'(STARVE_LIMIT);
  assign w_force_if     = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Grant logic: at most one grant, none while in reset
  // -------------------------------------------------------------------------
  always_comb begin
    w_d_gnt  = 1'b0;
    w_if_gnt = 1'b0;
    if (!rst) begin
      if (d_req_i && !(w_force_if && if_req_i)) begin
        w_d_gnt = 1'b1;
      end else if (if_req_i) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  assign if_gnt_o = w_if_gnt;
  assign d_gnt_o  = w_d_gnt;

  // -------------------------------------------------------------------------
  // SRAM mux: fields are zero when nothing is granted
  // -------------------------------------------------------------------------
  always_comb begin
    sram_en_o    = w_if_gnt | w_d_gnt;
    sram_we_o    = w_d_gnt & d_we_i;
    sram_addr_o  = '0;
    sram_wdata_o = 32'd0;
    sram_wmask_o = 4'd0;
    if (w_d_gnt) begin
      sram_addr_o = d_addr_i;
      if (d_we_i) begin
        sram_wdata_o = d_wdata_i;
        sram_wmask_o = d_wmask_i;
      end
    end else if (w_if_gnt) begin
      sram_addr_o = if_addr_i;
    end
  end

  // -------------------------------------------------------------------------
  // Response routing
  // -------------------------------------------------------------------------
  assign w_rd_gnt = w_if_gnt | (w_d_gnt & ~d_we_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_valid <= 1'b0;
      r_tag_is_d  <= 1'b0;
    end else begin
      r_tag_valid <= w_rd_gnt;
      r_tag_is_d  <= w_d_gnt;
    end
  end

  // Gated by rst so a read granted just before reset never produces rvalid.
  assign w_if_rvalid = r_tag_valid & ~r_tag_is_d & ~rst;
  assign w_d_rvalid  = r_tag_valid &  r_tag_is_d & ~rst;

  // Hold registers keep the last delivered word on the port not being served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      if (w_if_rvalid) r_if_rdata <= sram_rdata_i;
      if (w_d_rvalid)  r_d_rdata  <= sram_rdata_i;
    end
  end

  always_comb begin
    if_rvalid_o = w_if_rvalid;
    d_rvalid_o  = w_d_rvalid;
    if_rdata_o  = 32'd0;
    d_rdata_o   = 32'd0;
    if (!rst) begin
      if_rdata_o = w_if_rvalid ? sram_rdata_i : r_if_rdata;
      d_rdata_o  = w_d_rvalid  ? sram_rdata_i : r_d_rdata;
    end
  end

endmodule
